// File: rtl/sync_fifo.sv
// Single-clock FIFO on a register-file array with occupancy count, programmable
// almost-full/almost-empty thresholds, registered read data and sticky error flags.
module sync_fifo #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4,
    parameter int AF_LEVEL  = (1 << ADDR_SIZE) - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    input  logic                 clr_err,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam int CW    = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [ADDR_SIZE:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [ADDR_SIZE:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_SIZE:0]   rd_ptr_reg, rd_ptr_next;
    logic [ADDR_SIZE:0]   count_reg, count_next;
    logic [DATA_SIZE-1:0] rd_data_reg;
    logic                 rd_valid_reg;
    logic                 overflow_reg, overflow_next;
    logic                 underflow_reg, underflow_next;
    logic                 wr_acc, rd_acc;

    // Status flags are pure decodes of the registered count, so requests never
    // reach them combinationally.
    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);
    assign count        = count_reg;
    assign rd_data      = rd_data_reg;
    assign rd_valid     = rd_valid_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    always_comb begin
        rd_acc         = rd_en & ~empty;
        // A read from a full FIFO frees a slot in the same edge.
        wr_acc         = wr_en & (~full | rd_en);
        wr_ptr_next    = wr_ptr_reg + (wr_acc ? CW'(1) : CW'(0));
        rd_ptr_next    = rd_ptr_reg + (rd_acc ? CW'(1) : CW'(0));
        count_next     = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        // Set takes priority over clear when both happen in one cycle.
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (clr_err) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (wr_en & ~wr_acc) overflow_next  = 1'b1;
        if (rd_en & ~rd_acc) underflow_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_reg[ADDR_SIZE-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            rd_valid_reg  <= rd_acc;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            if (rd_acc) begin
                rd_data_reg <= mem[rd_ptr_reg[ADDR_SIZE-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus randomized bench for sync_fifo, checked against a queue-based
// reference model of the FIFO's externally visible behaviour.
module tb_sync_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          clr_err;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_SIZE(DW),
        .ADDR_SIZE(AW),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .clr_err     (clr_err),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the FIFO contents as a queue plus the visible registers.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_data  = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",        32'(count),        32'(n));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("almost_full",  32'(almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("rd_valid",     32'(rd_valid),     32'(m_valid));
        chk("rd_data",      32'(rd_data),      32'(m_data));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
    endtask

    // One clock of stimulus: drive inputs, advance the model, then check #1 after the edge.
    task automatic cycle(input logic r_st, input logic w, input logic [DW-1:0] d,
                         input logic r, input logic c);
        logic racc, wacc;
        rst = r_st; wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        if (r_st) begin
            q.delete();
            m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            racc = r && (q.size() != 0);
            wacc = w && ((q.size() != DEPTH) || r);
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (w && !wacc) m_ovf = 1'b1;
            if (r && !racc) m_unf = 1'b1;
            m_valid = racc;
            if (racc) m_data = q.pop_front();
            if (wacc) q.push_back(d);
        end
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b wr=%0b/%02h rd=%0b clr=%0b -> count=%0d rd_valid=%0b rd_data=%02h ovf=%0b unf=%0b",
                 $time, r_st, w, d, r, c, count, rd_valid, rd_data, overflow, underflow);
        check_all();
    endtask

    initial begin
        int wleft, rleft;
        logic w, r;

        // Reset state
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
        chk("reset_count", 32'(count), 32'd0);

        // Fill 0x01..0x10
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == AF - 1) chk("af_below_14", 32'(almost_full), 32'd0);
            if (i == AF)     chk("af_at_14",    32'(almost_full), 32'd1);
        end
        chk("full_after_16", 32'(full), 32'd1);

        // Write while full: rejected, sticky overflow, then cleared
        cycle(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Simultaneous read/write at full
        cycle(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        chk("full_rw_data", 32'(rd_data), 32'h01);
        chk("full_rw_count", 32'(count), 32'd16);

        // Drain: 0x02..0x10 then 0x55, back-to-back
        while (q.size() > 0) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("last_drained", 32'(rd_data), 32'h55);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Read+write on empty: read rejected, write accepted
        cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        chk("empty_rw_unf", 32'(underflow), 32'd1);
        chk("empty_rw_count", 32'(count), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("empty_rw_data", 32'(rd_data), 32'h77);

        // Randomized interleave across pointer wrap, occupancy kept in 3..9
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        wleft = 40;
        rleft = 40;
        for (int i = 0; i < 400 && (wleft > 0 || rleft > 0); i++) begin
            w = (wleft > 0) && (q.size() < 9) && ($urandom_range(0, 1) == 1);
            r = (rleft > 0) && (q.size() > 3) && ($urandom_range(0, 1) == 1);
            if (w) wleft--;
            if (r) rleft--;
            cycle(1'b0, w, 8'($urandom), r, 1'b0);
        end
        chk("random_done", 32'(wleft + rleft), 32'd0);
        while (q.size() > 0) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-drain at count 5
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_data", 32'(rd_data), 32'd0);
        chk("rst_mid_valid", 32'(rd_valid), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_unf", 32'(underflow), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
